// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one shift per clock.
// Start/busy/done handshake; o_bcd is registered and holds the last result.
module bin2bcd_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_done;

  state_e             w_state_nxt;
  logic [BIN_W-1:0]   w_bin_nxt;
  logic [BCD_W-1:0]   w_scratch_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [BCD_W-1:0]   w_bcd_nxt;
  logic               w_done_nxt;
  logic [BCD_W-1:0]   w_corr;
  logic [BCD_W-1:0]   w_shifted;

  // Per-digit add-3 correction; digits are independent, no carry between them.
  always_comb begin
    w_corr = r_scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_corr[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
    w_shifted = {w_corr[BCD_W-2:0], r_bin[BIN_W-1]};
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_state_nxt   = r_state;
    w_bin_nxt     = r_bin;
    w_scratch_nxt = r_scratch;
    w_cnt_nxt     = r_cnt;
    w_bcd_nxt     = r_bcd;
    w_done_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_bin_nxt     = i_bin;
          w_scratch_nxt = '0;
          w_cnt_nxt     = CNT_W'(BIN_W);
          w_state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        w_bin_nxt     = r_bin << 1;
        w_scratch_nxt = w_shifted;
        w_cnt_nxt     = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_bcd_nxt   = w_shifted;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bin     <= w_bin_nxt;
      r_scratch <= w_scratch_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bcd     <= w_bcd_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign o_busy = (r_state == SHIFT);
  assign o_done = r_done;
  assign o_bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: expected BCD pushed on start acceptance,
// popped and compared by a monitor whenever o_done is seen.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;
  localparam int LIMIT  = 40;

  logic                i_clk;
  logic                i_rst_n;
  logic                i_start;
  logic [BIN_W-1:0]    i_bin;
  logic                o_busy;
  logic                o_done;
  logic [4*DIGITS-1:0] o_bcd;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [4*DIGITS-1:0] sb[$];

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_bin   (i_bin),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_bcd   (o_bcd)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: decimal digits by repeated division.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Scoreboard monitor: samples 1 time unit after each active edge.
  always @(posedge i_clk) begin
    #1;
    if (o_done === 1'b1) begin
      logic [4*DIGITS-1:0] exp_v;
      n_done++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_done: o_bcd=%h but no conversion expected", o_bcd);
      end else begin
        exp_v = sb.pop_front();
        if (o_bcd !== exp_v) begin
          n_bad++;
          $display("FAIL result: o_bcd=%h expected=%h", o_bcd, exp_v);
        end
      end
      for (int k = 0; k < DIGITS; k++) begin
        n_cmp++;
        if (o_bcd[4*k +: 4] > 4'd9) begin
          n_bad++;
          $display("FAIL nibble_range: digit%0d=%h expected<=9", k, o_bcd[4*k +: 4]);
        end
      end
    end
  end

  // Drive a start at the current (post-edge) time; accepted on the next edge.
  task automatic do_start(input logic [BIN_W-1:0] v);
    i_start = 1'b1;
    i_bin   = v;
    @(posedge i_clk);
    sb.push_back(to_bcd(int'(v)));
    #1;
    i_start = 1'b0;
    i_bin   = BIN_W'($urandom);
  endtask

  // Call at the acceptance sample; returns at the o_done sample.
  task automatic run_until_done(output int cyc, output int busy_cyc, output bit held);
    logic [4*DIGITS-1:0] hold;
    hold     = o_bcd;
    cyc      = 0;
    busy_cyc = (o_busy === 1'b1) ? 1 : 0;
    held     = 1'b1;
    while (cyc < LIMIT) begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_done === 1'b1) break;
      if (o_busy === 1'b1) busy_cyc++;
      if (o_bcd !== hold) held = 1'b0;
    end
    if (o_done !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: no o_done within %0d cycles", LIMIT);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_bin   = '0;
    idle_cycles(3);
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    n_cmp++; if (o_bcd !== '0) begin n_bad++; $display("FAIL reset_bcd: got %h want 0", o_bcd); end
    i_rst_n = 1'b1;
    idle_cycles(2);
  endtask

  // Common single-conversion checks: busy, latency, hold, done pulse width.
  task automatic single_conv(input string name, input logic [BIN_W-1:0] v);
    int cyc, busy_cyc;
    bit held;
    do_start(v);
    n_cmp++; if (o_busy !== 1'b1) begin n_bad++; $display("FAIL %s_busy_start: got %b want 1", name, o_busy); end
    run_until_done(cyc, busy_cyc, held);
    n_cmp++; if (cyc != BIN_W) begin n_bad++; $display("FAIL %s_latency: got %0d want %0d", name, cyc, BIN_W); end
    n_cmp++; if (busy_cyc != BIN_W) begin n_bad++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, busy_cyc, BIN_W); end
    n_cmp++; if (!held) begin n_bad++; $display("FAIL %s_hold: o_bcd changed before done (got 0 want 1)", name); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_at_done: got %b want 0", name, o_busy); end
    idle_cycles(1);
    n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL %s_done_width: got %b want 0", name, o_done); end
    n_cmp++; if (o_bcd !== to_bcd(int'(v))) begin n_bad++; $display("FAIL %s_held_after: got %h want %h", name, o_bcd, to_bcd(int'(v))); end
  endtask

  task automatic test_zero();
    single_conv("zero", 16'd0);
    idle_cycles(2);
  endtask

  task automatic test_max();
    single_conv("max", 16'd65535);
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [BIN_W-1:0] vals [3];
    int cyc, busy_cyc;
    bit held;
    vals[0] = 16'd1234; vals[1] = 16'd9; vals[2] = 16'd10;
    do_start(vals[0]);
    run_until_done(cyc, busy_cyc, held);
    for (int i = 1; i < 3; i++) begin
      do_start(vals[i]);
      run_until_done(cyc, busy_cyc, held);
      n_cmp++; if (cyc + 1 != BIN_W + 1) begin n_bad++; $display("FAIL b2b_gap%0d: got %0d want %0d", i, cyc + 1, BIN_W + 1); end
      n_cmp++; if (!held) begin n_bad++; $display("FAIL b2b_hold%0d: o_bcd changed mid-conversion (got 0 want 1)", i); end
    end
    idle_cycles(3);
    n_cmp++; if (o_bcd !== 20'h00010) begin n_bad++; $display("FAIL b2b_final_hold: got %h want 00010", o_bcd); end
  endtask

  task automatic test_busy_ignore();
    int d0, cyc, busy_cyc;
    bit held;
    d0 = n_done;
    do_start(16'd500);
    idle_cycles(4);
    i_start = 1'b1;
    i_bin   = 16'd999;
    idle_cycles(1);
    i_start = 1'b0;
    i_bin   = 16'd777;
    run_until_done(cyc, busy_cyc, held);
    n_cmp++; if (cyc != BIN_W - 5) begin n_bad++; $display("FAIL ignore_latency: got %0d want %0d", cyc, BIN_W - 5); end
    idle_cycles(25);
    n_cmp++; if (n_done - d0 != 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d want 1", n_done - d0); end
    n_cmp++; if (o_bcd !== 20'h00500) begin n_bad++; $display("FAIL ignore_result: got %h want 00500", o_bcd); end
  endtask

  task automatic test_reset_mid();
    int d0, cyc, busy_cyc;
    bit held;
    do_start(16'd4321);
    idle_cycles(7);
    #2;
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_async: got %b want 0", o_busy); end
    n_cmp++; if (o_bcd !== '0) begin n_bad++; $display("FAIL rstmid_bcd_async: got %h want 0", o_bcd); end
    d0 = n_done;
    idle_cycles(2);
    i_rst_n = 1'b1;
    idle_cycles(20);
    n_cmp++; if (n_done != d0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", n_done - d0); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    n_cmp++; if (o_bcd !== '0) begin n_bad++; $display("FAIL rstmid_bcd: got %h want 0", o_bcd); end
    do_start(16'd4321);
    run_until_done(cyc, busy_cyc, held);
    n_cmp++; if (o_bcd !== 20'h04321) begin n_bad++; $display("FAIL rstmid_restart: got %h want 04321", o_bcd); end
    idle_cycles(1);
  endtask

  task automatic test_random();
    int cyc, busy_cyc;
    bit held;
    logic [BIN_W-1:0] v;
    for (int i = 0; i < 1100; i++) begin
      if (i < 6) begin
        case (i)
          0: v = 16'd1;     1: v = 16'd99;    2: v = 16'd100;
          3: v = 16'd9999;  4: v = 16'd10000; default: v = 16'd65534;
        endcase
      end else begin
        v = BIN_W'($urandom);
      end
      do_start(v);
      run_until_done(cyc, busy_cyc, held);
      n_cmp++; if (cyc != BIN_W) begin n_bad++; $display("FAIL rand_latency: value %0d got %0d want %0d", v, cyc, BIN_W); end
      idle_cycles(int'($urandom_range(0, 3)));
    end
    idle_cycles(2);
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL rand_leftover: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_max();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
